// File: rtl/ex_mem_pkg.sv
// Shared defines for the ex/mem pipeline register: stall bit indices, reset level,
// zero word, default widths and the capture/bubble/hold/flush decision.
package ex_mem_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int ADDR_W_DEF  = 5;
  localparam int STALL_W_DEF = 6;

  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;

  localparam logic        RST_ACTIVE = 1'b0;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

  typedef enum logic [1:0] {
    ACT_CAPTURE = 2'd0,
    ACT_BUBBLE  = 2'd1,
    ACT_HOLD    = 2'd2,
    ACT_FLUSH   = 2'd3
  } ex_mem_act_e;

  // Flush beats every stall; ex not stalled captures even if mem claims a stall.
  function automatic ex_mem_act_e ex_mem_decode(input logic flush,
                                                input logic stall_ex,
                                                input logic stall_mem);
    ex_mem_act_e act;
    if (flush) begin
      act = ACT_FLUSH;
    end else if (!stall_ex) begin
      act = ACT_CAPTURE;
    end else if (!stall_mem) begin
      act = ACT_BUBBLE;
    end else begin
      act = ACT_HOLD;
    end
    return act;
  endfunction

endpackage

// File: rtl/ex_mem.sv
// ex/mem pipeline register with bubble/hold/flush handling.
// Macro EX_MEM_HILO_EN enables the HI/LO and multi-cycle partial-state registers.
module ex_mem
  import ex_mem_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int STALL_W = STALL_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STALL_W-1:0]  stall,
  input  logic                flush,
  input  logic [ADDR_W-1:0]   ex_waddr,
  input  logic                ex_we,
  input  logic [DATA_W-1:0]   ex_wdata,
  input  logic                ex_whilo,
  input  logic [DATA_W-1:0]   ex_hi,
  input  logic [DATA_W-1:0]   ex_lo,
  input  logic [2*DATA_W-1:0] hilo_temp_i,
  input  logic [1:0]          cnt_i,
  output logic [ADDR_W-1:0]   mem_waddr,
  output logic                mem_we,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_whilo,
  output logic [DATA_W-1:0]   mem_hi,
  output logic [DATA_W-1:0]   mem_lo,
  output logic                mem_valid,
  output logic [2*DATA_W-1:0] hilo_temp_o,
  output logic [1:0]          cnt_o
);

  localparam logic [DATA_W-1:0] ZERO_D = DATA_W'(ZERO_WORD);

  ex_mem_act_e act_s;
  logic        unused_stall_s;

  // Single decision shared by the register-write and HI/LO slots.
  always_comb begin
    act_s = ex_mem_decode(flush, stall[STALL_EX], stall[STALL_MEM]);
  end

  // Only the ex and mem stall bits matter to this stage.
  assign unused_stall_s = ^stall;

  // Register-write slot and validity flag toward mem.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      mem_waddr <= {ADDR_W{1'b0}};
      mem_we    <= 1'b0;
      mem_wdata <= ZERO_D;
      mem_valid <= 1'b0;
    end else begin
      case (act_s)
        ACT_CAPTURE: begin
          mem_waddr <= ex_waddr;
          mem_we    <= ex_we;
          mem_wdata <= ex_wdata;
          mem_valid <= 1'b1;
        end
        ACT_HOLD: begin
          mem_waddr <= mem_waddr;
          mem_we    <= mem_we;
          mem_wdata <= mem_wdata;
          mem_valid <= mem_valid;
        end
        default: begin
          mem_waddr <= {ADDR_W{1'b0}};
          mem_we    <= 1'b0;
          mem_wdata <= ZERO_D;
          mem_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef EX_MEM_HILO_EN
  // HI/LO slot plus the partial multiply state that loops back to ex while it stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      mem_whilo   <= 1'b0;
      mem_hi      <= ZERO_D;
      mem_lo      <= ZERO_D;
      hilo_temp_o <= {(2*DATA_W){1'b0}};
      cnt_o       <= 2'b00;
    end else begin
      case (act_s)
        ACT_CAPTURE: begin
          mem_whilo   <= ex_whilo;
          mem_hi      <= ex_hi;
          mem_lo      <= ex_lo;
          hilo_temp_o <= {(2*DATA_W){1'b0}};
          cnt_o       <= 2'b00;
        end
        ACT_BUBBLE: begin
          mem_whilo   <= 1'b0;
          mem_hi      <= ZERO_D;
          mem_lo      <= ZERO_D;
          hilo_temp_o <= hilo_temp_i;
          cnt_o       <= cnt_i;
        end
        ACT_HOLD: begin
          mem_whilo   <= mem_whilo;
          mem_hi      <= mem_hi;
          mem_lo      <= mem_lo;
          hilo_temp_o <= hilo_temp_o;
          cnt_o       <= cnt_o;
        end
        default: begin
          mem_whilo   <= 1'b0;
          mem_hi      <= ZERO_D;
          mem_lo      <= ZERO_D;
          hilo_temp_o <= {(2*DATA_W){1'b0}};
          cnt_o       <= 2'b00;
        end
      endcase
    end
  end
`else
  logic unused_hilo_s;

  assign unused_hilo_s = ^{ex_whilo, ex_hi, ex_lo, hilo_temp_i, cnt_i};
  assign mem_whilo     = 1'b0;
  assign mem_hi        = ZERO_D;
  assign mem_lo        = ZERO_D;
  assign hilo_temp_o   = {(2*DATA_W){1'b0}};
  assign cnt_o         = 2'b00;
`endif

endmodule

// File: tb/tb_ex_mem.sv
// Self-checking bench for ex_mem: directed vector table, randomized run against a
// rule-level reference model, and an asynchronous-reset-during-hold sequence.
module tb_ex_mem;

`ifdef EX_MEM_HILO_EN
  localparam bit HILO = 1'b1;
`else
  localparam bit HILO = 1'b0;
`endif

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        valid;
    logic [63:0] temp;
    logic [1:0]  cnt;
  } st_t;

  typedef struct {
    logic        flush;
    logic [5:0]  stall;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [63:0] temp_i;
    logic [1:0]  cnt_i;
    st_t         exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall = 6'h00;
  logic        flush = 1'b0;
  logic [4:0]  ex_waddr = 5'd0;
  logic        ex_we = 1'b0;
  logic [31:0] ex_wdata = 32'h0;
  logic        ex_whilo = 1'b0;
  logic [31:0] ex_hi = 32'h0;
  logic [31:0] ex_lo = 32'h0;
  logic [63:0] hilo_temp_i = 64'h0;
  logic [1:0]  cnt_i = 2'b00;
  logic [4:0]  mem_waddr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        mem_whilo;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic        mem_valid;
  logic [63:0] hilo_temp_o;
  logic [1:0]  cnt_o;

  int   checks = 0;
  int   failures = 0;
  st_t  model = '0;
  vec_t tbl[13];

  ex_mem dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_waddr(ex_waddr), .ex_we(ex_we), .ex_wdata(ex_wdata),
    .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo),
    .hilo_temp_i(hilo_temp_i), .cnt_i(cnt_i),
    .mem_waddr(mem_waddr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .mem_valid(mem_valid), .hilo_temp_o(hilo_temp_o), .cnt_o(cnt_o)
  );

  always #5 clk = ~clk;

  function automatic st_t mask(st_t s);
    st_t m = s;
    if (!HILO) begin
      m.whilo = 1'b0;
      m.hi    = 32'h0;
      m.lo    = 32'h0;
      m.temp  = 64'h0;
      m.cnt   = 2'b00;
    end
    return m;
  endfunction

  // Reference: what the mem slot should hold after an edge with the current inputs.
  function automatic st_t model_next(st_t cur);
    st_t n = cur;
    if (flush) begin
      n = '0;
    end else if (!stall[3]) begin
      n = '{we: ex_we, waddr: ex_waddr, wdata: ex_wdata, whilo: ex_whilo,
            hi: ex_hi, lo: ex_lo, valid: 1'b1, temp: 64'h0, cnt: 2'b00};
    end else if (!stall[4]) begin
      n = '0;
      n.temp = hilo_temp_i;
      n.cnt  = cnt_i;
    end
    return mask(n);
  endfunction

  task automatic chk(input string tag, input string name,
                     input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s actual=%0h expected=%0h", tag, name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input st_t e);
    chk(tag, "mem_we",      64'(mem_we),      64'(e.we));
    chk(tag, "mem_waddr",   64'(mem_waddr),   64'(e.waddr));
    chk(tag, "mem_wdata",   64'(mem_wdata),   64'(e.wdata));
    chk(tag, "mem_whilo",   64'(mem_whilo),   64'(e.whilo));
    chk(tag, "mem_hi",      64'(mem_hi),      64'(e.hi));
    chk(tag, "mem_lo",      64'(mem_lo),      64'(e.lo));
    chk(tag, "mem_valid",   64'(mem_valid),   64'(e.valid));
    chk(tag, "hilo_temp_o", hilo_temp_o,      e.temp);
    chk(tag, "cnt_o",       64'(cnt_o),       64'(e.cnt));
  endtask

  task automatic drive(input logic fl, input logic [5:0] st, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd, input logic whl,
                       input logic [31:0] h, input logic [31:0] l,
                       input logic [63:0] tmp, input logic [1:0] c);
    flush = fl; stall = st; ex_we = we; ex_waddr = wa; ex_wdata = wd;
    ex_whilo = whl; ex_hi = h; ex_lo = l; hilo_temp_i = tmp; cnt_i = c;
  endtask

  task automatic step();
    @(posedge clk);
    model = model_next(model);
    #1;
  endtask

  initial begin
    //            flush stall  we wa     wdata         whl hi            lo            temp_i                  cnt   exp: we wa wdata  whl hi lo valid temp cnt
    tbl[0]  = '{1'b0, 6'h00, 1'b1, 5'd7,  32'hDEADBEEF, 1'b1, 32'h11111111, 32'h22222222, 64'h5, 2'd3,
                '{1'b1, 5'd7, 32'hDEADBEEF, 1'b1, 32'h11111111, 32'h22222222, 1'b1, 64'h0, 2'd0}};
    tbl[1]  = '{1'b0, 6'h0F, 1'b1, 5'd3,  32'h00000055, 1'b1, 32'h33, 32'h44, 64'h1, 2'd1,
                '{1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 64'h1, 2'd1}};
    tbl[2]  = '{1'b0, 6'h00, 1'b1, 5'd9,  32'h12345678, 1'b0, 32'h0, 32'h0, 64'h2, 2'd2,
                '{1'b1, 5'd9, 32'h12345678, 1'b0, 32'h0, 32'h0, 1'b1, 64'h0, 2'd0}};
    tbl[3]  = '{1'b0, 6'h1F, 1'b0, 5'd1,  32'hAAAA0001, 1'b1, 32'h5, 32'h6, 64'h7, 2'd3,
                '{1'b1, 5'd9, 32'h12345678, 1'b0, 32'h0, 32'h0, 1'b1, 64'h0, 2'd0}};
    tbl[4]  = '{1'b0, 6'h1F, 1'b1, 5'd2,  32'hAAAA0002, 1'b1, 32'h7, 32'h8, 64'h8, 2'd2,
                '{1'b1, 5'd9, 32'h12345678, 1'b0, 32'h0, 32'h0, 1'b1, 64'h0, 2'd0}};
    tbl[5]  = '{1'b0, 6'h1F, 1'b1, 5'd3,  32'hAAAA0003, 1'b0, 32'h9, 32'hA, 64'h9, 2'd1,
                '{1'b1, 5'd9, 32'h12345678, 1'b0, 32'h0, 32'h0, 1'b1, 64'h0, 2'd0}};
    tbl[6]  = '{1'b0, 6'h10, 1'b0, 5'd4,  32'h0000CAFE, 1'b1, 32'hABCD0000, 32'h1234, 64'h3, 2'd3,
                '{1'b0, 5'd4, 32'h0000CAFE, 1'b1, 32'hABCD0000, 32'h1234, 1'b1, 64'h0, 2'd0}};
    tbl[7]  = '{1'b0, 6'h0F, 1'b1, 5'd5,  32'h6, 1'b1, 32'h7, 32'h8, 64'hABCD, 2'd2,
                '{1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 64'hABCD, 2'd2}};
    tbl[8]  = '{1'b0, 6'h1F, 1'b1, 5'd6,  32'h7, 1'b1, 32'h8, 32'h9, 64'h9, 2'd1,
                '{1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 64'hABCD, 2'd2}};
    tbl[9]  = '{1'b1, 6'h1F, 1'b1, 5'd8,  32'h9, 1'b1, 32'hA, 32'hB, 64'hF, 2'd3,
                '{1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0}};
    tbl[10] = '{1'b0, 6'h0F, 1'b0, 5'd0,  32'h0, 1'b0, 32'h0, 32'h0, 64'hFFFFFFFF00000001, 2'd3,
                '{1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 64'hFFFFFFFF00000001, 2'd3}};
    tbl[11] = '{1'b1, 6'h00, 1'b1, 5'd2,  32'h3, 1'b1, 32'h4, 32'h5, 64'h6, 2'd1,
                '{1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0}};
    tbl[12] = '{1'b0, 6'h27, 1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 32'h1, 64'h6, 2'd2,
                '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 32'h1, 1'b1, 64'h0, 2'd0}};

    #1 rst = 1'b0;
    #2;
    model = '0;
    chk_all("reset", model);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].flush, tbl[i].stall, tbl[i].we, tbl[i].waddr, tbl[i].wdata,
            tbl[i].whilo, tbl[i].hi, tbl[i].lo, tbl[i].temp_i, tbl[i].cnt_i);
      step();
      chk_all($sformatf("vec%0d", i), mask(tbl[i].exp));
    end

    for (int i = 0; i < 400; i++) begin
      logic [5:0] st;
      int         sel;
      sel = int'($urandom_range(0, 9));
      st  = 6'($urandom);
      if (sel < 4)      st = st & 6'b100111;
      else if (sel < 6) st = (st & 6'b100111) | 6'b001000;
      else if (sel < 9) st = st | 6'b011000;
      drive(($urandom_range(0, 9) == 0), st, 1'($urandom), 5'($urandom), $urandom,
            1'($urandom), $urandom, $urandom, {$urandom, $urandom}, 2'($urandom));
      step();
      chk_all($sformatf("rnd%0d", i), model);
    end

    drive(1'b0, 6'h00, 1'b1, 5'd12, 32'h0BADF00D, 1'b1, 32'hFFFFFFFF, 32'h77, 64'h0, 2'd3);
    step();
    chk_all("async_cap", model);
    drive(1'b0, 6'h1F, 1'b0, 5'd1, 32'h1, 1'b0, 32'h2, 32'h3, 64'h4, 2'd1);
    step();
    chk_all("async_hold", model);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    model = '0;
    chk_all("async_rst", model);
    @(posedge clk);
    #1;
    chk_all("rst_low_edge", model);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk_all("post_rst_hold", model);
    drive(1'b0, 6'h00, 1'b1, 5'd21, 32'hFEEDFACE, 1'b1, 32'hFFFFFFFF, 32'h5, 64'h0, 2'd2);
    step();
    chk_all("post_rst_cap", model);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ex_mem.md
EX_MEM -- requirements
Module: ex_mem

Interface
REQ-001 The block SHALL have parameters DATA_W (default 32, register/data width), ADDR_W (default 5, register address width) and STALL_W (default 6, stall vector width, one bit per pipeline stage: pc, if, id, ex, mem, wb).
REQ-002 clk  input  1  Rising-edge clock; the one clock for the block.
REQ-003 rst  input  1  Asynchronous, active-low reset.
REQ-004 stall  input  STALL_W  Stage stall vector from the pipeline controller; bit 3 = ex, bit 4 = mem.
REQ-005 flush  input  1  Exception flush: kill the current ex result.
REQ-006 ex_waddr  input  ADDR_W  Destination register address from ex.
REQ-007 ex_we  input  1  Register write enable from ex.
REQ-008 ex_wdata  input  DATA_W  Result data from ex.
REQ-009 ex_whilo  input  1  HI/LO write enable from ex.
REQ-010 ex_hi, ex_lo  input  DATA_W each  HI/LO write data from ex.
REQ-011 hilo_temp_i  input  2*DATA_W  Partial multiply-accumulate result from ex.
REQ-012 cnt_i  input  2  Multi-cycle operation step count from ex.
REQ-013 mem_waddr, mem_we, mem_wdata  output  ADDR_W/1/DATA_W  Registered register-write fields to mem.
REQ-014 mem_whilo, mem_hi, mem_lo  output  1/DATA_W/DATA_W  Registered HI/LO fields to mem.
REQ-015 mem_valid  output  1  High when the mem-side slot holds a real instruction and not a bubble.
REQ-016 hilo_temp_o, cnt_o  output  2*DATA_W/2  Held partial state, returned to ex.

Function
REQ-017 The block SHALL update all registered outputs only on the rising clk edge; it SHALL have no combinational path from input to output.
REQ-018 Capture: when flush=0 and stall[3]=0, the block SHALL load every mem_* field from the matching ex_* input, set mem_valid=1, clear hilo_temp_o to 0 and clear cnt_o to 0.
REQ-019 Bubble: when flush=0, stall[3]=1 and stall[4]=0, the block SHALL set mem_we=0, mem_whilo=0, mem_waddr=0, mem_wdata=0, mem_hi=0, mem_lo=0 and mem_valid=0.
REQ-020 In the bubble case of REQ-019, the block SHALL load hilo_temp_o from hilo_temp_i and cnt_o from cnt_i.
REQ-021 Hold: when flush=0, stall[3]=1 and stall[4]=1, the block SHALL keep every output unchanged.
REQ-022 Flush: flush=1 SHALL take priority over every stall combination and SHALL produce the bubble values of REQ-019.
REQ-023 On flush, hilo_temp_o and cnt_o SHALL also be cleared to 0.
REQ-024 stall[3]=0 with stall[4]=1 is illegal; the block SHALL treat it as capture (REQ-018).
REQ-025 Latency: an ex result SHALL appear on the mem_* outputs exactly 1 cycle after the edge on which it is captured.
REQ-026 A result held across N hold cycles SHALL reach mem unchanged, with no duplicate and no loss.
REQ-027 In the capture case, cnt_o SHALL always be 0 on the edge that follows, whatever cnt_i is.

Reset
REQ-028 rst=0 SHALL clear every output to 0, mem_valid included, immediately and independent of clk.
REQ-029 Reset during a hold SHALL discard the held result; the first edge after release SHALL apply REQ-018 to REQ-022 normally.

Configuration
REQ-030 The macro EX_MEM_HILO_EN SHALL control the HI/LO path.
REQ-031 When EX_MEM_HILO_EN is defined, the HI/LO and multi-cycle registers SHALL behave as in REQ-018 to REQ-023.
REQ-032 When EX_MEM_HILO_EN is undefined, the ports SHALL remain; mem_whilo, mem_hi, mem_lo, hilo_temp_o and cnt_o SHALL be constant 0, and their registers SHALL NOT be synthesized.

Structure
REQ-033 The stall bit indices (STALL_EX=3, STALL_MEM=4), the reset-active level, ZeroWord and the width constants SHALL be defined in the shared defines package, not inside the block.
REQ-034 The block SHALL be written as one module without sub-modules; the capture/bubble/hold decision SHALL be a single priority structure: reset, then flush, then stall.

Verification
REQ-035 Capture: stall=000000, ex_we=1, ex_waddr=5'd7, ex_wdata=32'hDEADBEEF -> one cycle later mem_we=1, mem_waddr=7, mem_wdata=32'hDEADBEEF, mem_valid=1.
REQ-036 Bubble: stall=001111, cnt_i=2'b01, hilo_temp_i=64'h1 -> mem_we=0, mem_valid=0, cnt_o=1, hilo_temp_o=1; the next stall=000000 edge clears cnt_o to 0.
REQ-037 Hold: capture wdata=32'h12345678, then stall=011111 for 3 cycles with changing ex inputs -> mem_wdata stays 32'h12345678 and mem_valid stays 1 throughout.
REQ-038 Flush priority: flush=1 together with stall=011111 -> mem_we=0, mem_valid=0, cnt_o=0 on the next edge.
REQ-039 Async reset: drive rst=0 mid-cycle during a hold -> all outputs go to 0 before the next clk edge.
REQ-040 Config: build without EX_MEM_HILO_EN and drive ex_whilo=1, ex_hi=32'hFFFFFFFF -> mem_whilo=0 and mem_hi=0 on every cycle.
